shift_seq_unit: RTL and testbench

Parametrised, sequential successor to the board-level 8-bit barrel shifter. Executes one shift, rotate or LFSR operation per start pulse, iteratively, one bit-step per clock, over `shamt` cycles. Provides a start/busy/done handshake plus carry and zero flags. Sits between the switch/button inputs and the LED outputs on the board top, and is reusable as a generic datapath shift engine.

---
 rtl/shift_seq_pkg.sv | 29 ++
 rtl/shift_seq_unit_step.sv | 58 +++++
 rtl/shift_seq_unit.sv | 103 ++++++++++
 tb/tb_shift_seq_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the sequential shift/rotate/LFSR engine.
package shift_seq_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SLL  = 3'd2;
    localparam logic [2:0] OP_SRL  = 3'd3;
    localparam logic [2:0] OP_SRA  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ROR  = 3'd6;
    localparam logic [2:0] OP_LFSR = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Operations that complete without any stepping cycles.
    function automatic logic ends_at_once(input logic [2:0] op, input logic shamt_zero);
        return (op == OP_NOP) || (op == OP_LOAD) || shamt_zero;
    endfunction

    // NOP and LFSR continue from the current register; everything else starts from din.
    function automatic logic loads_din(input logic [2:0] op);
        return !((op == OP_NOP) || (op == OP_LFSR));
    endfunction

endpackage

// File: rtl/shift_seq_unit_step.sv
// Single-step datapath: one bit of shift, rotate or LFSR advance.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next,
    output logic             bit_out
);

    logic fb_s;

    // Compute the next register value and the bit that leaves it.
    always_comb begin
        q_next  = q;
        bit_out = 1'b0;
        fb_s    = ^(q & TAPS);
        case (op)
            OP_SLL: begin
                q_next  = {q[WIDTH-2:0], 1'b0};
                bit_out = q[WIDTH-1];
            end
            OP_SRL: begin
                q_next  = {1'b0, q[WIDTH-1:1]};
                bit_out = q[0];
            end
            OP_SRA: begin
                q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                bit_out = q[0];
            end
            OP_ROL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                bit_out = q[WIDTH-1];
            end
            OP_ROR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                bit_out = q[0];
            end
            OP_LFSR: begin
                // An all-zero register would lock the LFSR; force a 1 in instead.
                if (q == {WIDTH{1'b0}}) begin
                    q_next = {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    q_next = {q[WIDTH-2:0], fb_s};
                end
                bit_out = q[WIDTH-1];
            end
            default: begin
                q_next  = q;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Iterative shift engine: one shift/rotate/LFSR step per clock, start/busy/done handshake.
module shift_seq_unit
    import shift_seq_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               SHW   = $clog2(WIDTH),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             carry,
    output logic             zero
);

    state_t           state_r;
    logic [2:0]       op_r;
    logic [SHW-1:0]   cnt_r;
    logic [WIDTH-1:0] q_r;
    logic             carry_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] step_q_s;
    logic             step_bit_s;

    shift_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .op      (op_r),
        .q       (q_r),
        .q_next  (step_q_s),
        .bit_out (step_bit_s)
    );

    // Control FSM, step counter and result registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            op_r    <= OP_NOP;
            cnt_r   <= {SHW{1'b0}};
            q_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        op_r    <= op;
                        cnt_r   <= shamt;
                        carry_r <= 1'b0;
                        if (loads_din(op)) begin
                            q_r <= din;
                        end
                        if (ends_at_once(op, shamt == {SHW{1'b0}})) begin
                            state_r <= S_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= S_RUN;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    q_r     <= step_q_s;
                    carry_r <= step_bit_s;
                    cnt_r   <= cnt_r - SHW'(1);
                    if (cnt_r == SHW'(1)) begin
                        state_r <= S_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign dout  = q_r;
    assign carry = carry_r;
    assign zero  = (q_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_shift_seq_unit.sv
// Scoreboard bench for shift_seq_unit: random and directed requests against a reference model.
module tb_shift_seq_unit;
    import shift_seq_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [2:0] shamt;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic [7:0] dout;
    logic       carry;
    logic       zero;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [7:0] q;
        logic       c;
        time        t0;
        int         steps;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] model_q;

    shift_seq_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .shamt (shamt),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .carry (carry),
        .zero  (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result of a whole request: {carry, q}
    function automatic logic [8:0] model(input logic [2:0] o, input int n,
                                         input logic [7:0] d, input logic [7:0] qcur);
        logic [7:0]        q;
        logic              c;
        logic signed [7:0] sd;
        q = qcur;
        c = 1'b0;
        case (o)
            OP_NOP:  q = qcur;
            OP_LOAD: q = d;
            OP_SLL: begin q = d << n; if (n > 0) c = d[8-n]; end
            OP_SRL: begin q = d >> n; if (n > 0) c = d[n-1]; end
            OP_SRA: begin sd = d; q = sd >>> n; if (n > 0) c = d[n-1]; end
            OP_ROL: begin
                if (n > 0) begin q = (d << n) | (d >> (8 - n)); c = q[0]; end
                else q = d;
            end
            OP_ROR: begin
                if (n > 0) begin q = (d >> n) | (d << (8 - n)); c = q[7]; end
                else q = d;
            end
            default: begin
                for (int i = 0; i < n; i++) begin
                    c = q[7];
                    if (q == 8'd0) q = 8'd1;
                    else q = ((q << 1) & 8'hFF) | 8'($countones(q & 8'hB8) % 2);
                end
            end
        endcase
        return {c, q};
    endfunction

    // Present one request on a falling edge and queue its expected outcome.
    task automatic issue(input logic [2:0] o, input logic [2:0] n, input logic [7:0] d);
        exp_t       e;
        logic [8:0] r;
        @(negedge clk);
        start = 1'b1; op = o; shamt = n; din = d;
        @(posedge clk);
        e.t0 = $time;
        r = model(o, int'(n), d, model_q);
        model_q = r[7:0];
        e.q = r[7:0];
        e.c = r[8];
        e.steps = (o == OP_NOP || o == OP_LOAD || n == 3'd0) ? 0 : int'(n);
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting samples where zero was high.
    task automatic wait_done(output int zero_hits);
        int k;
        k = 0;
        zero_hits = 0;
        while (done !== 1'b1 && k < 40) begin
            if (zero === 1'b1) zero_hits++;
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL timeout: done not seen within %0d cycles", k);
        end
    endtask

    // Scoreboard monitor: pop and compare whenever done is presented.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                done_seen++;
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no pending request at %0t", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("dout", 32'(dout), 32'(e.q));
                    chk("carry", 32'(carry), 32'(e.c));
                    chk("zero", 32'(zero), 32'(e.q == 8'd0));
                    chk("latency", 32'(($time - e.t0 - 5) / 10), 32'(e.steps));
                    chk("busy_len", 32'(busy_cnt), 32'(e.steps));
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        int         zh;
        int         zsum;
        int         dbefore;
        int         left;
        logic [7:0] seq [7];
        seq = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
        model_q = 8'd0;
        rst = 1'b0; start = 1'b0; op = 3'd0; shamt = 3'd0; din = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_zero", 32'(zero), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_carry", 32'(carry), 32'h0);
        rst = 1'b1;

        // Lockup escape from the all-zero reset state
        issue(OP_LFSR, 3'd1, 8'h00);
        wait_done(zh);

        // SRA with sign fill
        issue(OP_SRA, 3'd3, 8'h96);
        wait_done(zh);

        // Abort mid-operation by reset
        issue(OP_SRA, 3'd3, 8'h96);
        @(negedge clk);
        dbefore = done_seen;
        rst = 1'b0;
        #1;
        chk("abort_dout", 32'(dout), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_carry", 32'(carry), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        sbq.delete();
        model_q = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_done", 32'(done_seen), 32'(dbefore));

        // Rotate and zero-length shift
        issue(OP_ROL, 3'd1, 8'h81);
        wait_done(zh);
        issue(OP_SLL, 3'd0, 8'h5A);
        wait_done(zh);

        // LFSR run with intermediate sequence
        issue(OP_LOAD, 3'd0, 8'h01);
        wait_done(zh);
        issue(OP_LFSR, 3'd7, 8'h00);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("lfsr_seq", 32'(dout), 32'(seq[i]));
        end
        wait_done(zh);

        // Full LFSR period: 255 steps from 01 never passes through zero
        issue(OP_LOAD, 3'd0, 8'h01);
        wait_done(zh);
        zsum = 0;
        left = 255;
        while (left > 0) begin
            issue(OP_LFSR, (left >= 7) ? 3'd7 : 3'(left), 8'h00);
            left = left - ((left >= 7) ? 7 : left);
            wait_done(zh);
            zsum += zh;
        end
        chk("period_nonzero", 32'(zsum), 32'h0);
        chk("period_return", 32'(dout), 32'h01);

        // Starts during RUN and during the done cycle are ignored
        issue(OP_SRL, 3'd4, 8'hF0);
        @(negedge clk);
        start = 1'b1; op = OP_LOAD; din = 8'hAA;
        @(negedge clk);
        start = 1'b0;
        wait_done(zh);
        start = 1'b1; op = OP_LOAD; din = 8'hAA;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_prot_dout", 32'(dout), 32'h0F);
        chk("busy_prot_idle", 32'(busy), 32'h0);

        // Randomized requests
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom));
            wait_done(zh);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(sbq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
